mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mem_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the DDR3 memory arbiter.
// Holds the transaction FSM encoding, controller command codes and requester indices.
package mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WDATA = 2'd1,
      ST_CMD   = 2'd2,
      ST_RWAIT = 2'd3
   } state_t;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam int REQ_CPU = 0;
   localparam int REQ_GPU = 1;
   localparam int REQ_DMA = 2;

   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first valid requester scanning upward from ptr, wrapping modulo NREQ.
// Purely combinational; one-hot grant, any=1 when some requester is valid.
module rr_arbiter #(
   parameter int NREQ  = 3,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant,
   output logic             any
);

   int               idx;
   logic [PTR_W-1:0] sel;

   always_comb begin
      grant = '0;
      any   = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         sel = PTR_W'(idx);
         if (!any && valid[sel]) begin
            grant[sel] = 1'b1;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters onto one DDR3 app interface, one transaction in flight.
// Grant is a one-cycle req_ready in IDLE; app_rdy/app_wdf_rdy stall the FSM, completion is a one-cycle rsp_valid.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int NREQ   = 3,
   parameter int ADDR_W = 28,
   parameter int DATA_W = 512
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     calib_done,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     app_en,
   output logic [2:0]               app_cmd,
   output logic [ADDR_W-1:0]        app_addr,
   input  logic                     app_rdy,
   output logic                     app_wdf_wren,
   output logic                     app_wdf_end,
   output logic [DATA_W-1:0]        app_wdf_data,
   input  logic                     app_wdf_rdy,
   input  logic [DATA_W-1:0]        app_rd_data,
   input  logic                     app_rd_data_valid,
   output logic                     busy,
   output logic                     err
);

   localparam int               PTR_W    = ptr_width(NREQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic                err_q, err_d;

   logic [NREQ-1:0]     grant;
   logic                grant_any;
   logic                take;
   logic [PTR_W-1:0]    win;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [NREQ-1:0]     owner_oh;

   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .valid (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .any   (grant_any)
   );

   assign take = (state_q == ST_IDLE) && calib_done && grant_any;

   always_comb begin
      win       = '0;
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      owner_oh  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            win       = PTR_W'(i);
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
         owner_oh[i] = (owner_q == PTR_W'(i));
      end
   end

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               state_d = sel_we ? ST_WDATA : ST_CMD;
            end
         end
         ST_WDATA: begin
            if (app_wdf_rdy) begin
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            if (app_rdy) begin
               state_d = we_q ? ST_IDLE : ST_RWAIT;
            end
         end
         ST_RWAIT: begin
            if (app_rd_data_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath: transaction latch, round-robin pointer, completion and error tracking
   always_comb begin
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
      err_d       = err_q | (app_rd_data_valid && (state_q != ST_RWAIT));
      if (take) begin
         ptr_d   = (win == LAST_IDX) ? '0 : win + 1'b1;
         owner_d = win;
         we_d    = sel_we;
         addr_d  = sel_addr;
         wdata_d = sel_wdata;
      end
      if ((state_q == ST_CMD) && app_rdy && we_q) begin
         rsp_valid_d = owner_oh;
      end
      if ((state_q == ST_RWAIT) && app_rd_data_valid) begin
         rsp_valid_d = owner_oh;
         rsp_data_d  = app_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         owner_q     <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
      end
   end

   // FSM: outputs, forced quiet while rst is held since rst is only sampled at the edge
   always_comb begin
      req_ready    = (take && !rst) ? grant : '0;
      app_en       = (state_q == ST_CMD) && !rst;
      app_cmd      = we_q ? CMD_WRITE : CMD_READ;
      app_addr     = addr_q;
      app_wdf_wren = (state_q == ST_WDATA) && !rst;
      app_wdf_end  = (state_q == ST_WDATA) && !rst;
      app_wdf_data = wdata_q;
      rsp_valid    = rst ? '0 : rsp_valid_q;
      rsp_data     = rst ? '0 : rsp_data_q;
      busy         = (state_q != ST_IDLE) && !rst;
      err          = err_q && !rst;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, calibration gating, round-robin reads, stalled write/read, error and mid-read reset.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int NREQ   = 3;
   localparam int ADDR_W = 28;
   localparam int DATA_W = 512;

   logic                   clk;
   logic                   rst;
   logic                   calib_done;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        req_we;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic [NREQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]      rsp_data;
   logic                   app_en;
   logic [2:0]             app_cmd;
   logic [ADDR_W-1:0]      app_addr;
   logic                   app_rdy;
   logic                   app_wdf_wren;
   logic                   app_wdf_end;
   logic [DATA_W-1:0]      app_wdf_data;
   logic                   app_wdf_rdy;
   logic [DATA_W-1:0]      app_rd_data;
   logic                   app_rd_data_valid;
   logic                   busy;
   logic                   err;

   int n_chk;
   int n_bad;
   logic [ADDR_W-1:0] addr_tab [NREQ];
   logic [DATA_W-1:0] last_rd;
   logic [DATA_W-1:0] wr_pat;

   mem_arbiter #(
      .NREQ   (NREQ),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .calib_done        (calib_done),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_we            (req_we),
      .req_addr          (req_addr),
      .req_wdata         (req_wdata),
      .rsp_valid         (rsp_valid),
      .rsp_data          (rsp_data),
      .app_en            (app_en),
      .app_cmd           (app_cmd),
      .app_addr          (app_addr),
      .app_rdy           (app_rdy),
      .app_wdf_wren      (app_wdf_wren),
      .app_wdf_end       (app_wdf_end),
      .app_wdf_data      (app_wdf_data),
      .app_wdf_rdy       (app_wdf_rdy),
      .app_rd_data       (app_rd_data),
      .app_rd_data_valid (app_rd_data_valid),
      .busy              (busy),
      .err               (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after the edge; checks follow 1ns later, well before the next edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called in the grant cycle of a read by requester idx; command accepted after rdy_wait stall
   // cycles, read data returned 5 cycles after command acceptance.
   task automatic do_read(input int idx, input int rdy_wait, input logic [DATA_W-1:0] data,
                          input logic [NREQ-1:0] valid_after);
      logic [NREQ-1:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      #1 chk("grant", req_ready, oh);
      cyc();
      req_valid = valid_after;
      for (int k = 0; k < rdy_wait; k++) begin
         #1;
         chk("cmd_en_stall", app_en, 1'b1);
         chk("cmd_addr_stall", app_addr, addr_tab[idx]);
         cyc();
      end
      app_rdy = 1'b1;
      #1;
      chk("cmd_en", app_en, 1'b1);
      chk("cmd_code", app_cmd, CMD_READ);
      chk("cmd_addr", app_addr, addr_tab[idx]);
      cyc();
      app_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rwait_quiet", {app_en, app_wdf_wren, busy}, 3'b001);
         cyc();
      end
      app_rd_data       = data;
      app_rd_data_valid = 1'b1;
      cyc();
      app_rd_data_valid = 1'b0;
      app_rd_data       = '0;
      #1;
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_data", rsp_data, data);
      last_rd = data;
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      addr_tab[REQ_CPU] = 28'h0001000;
      addr_tab[REQ_GPU] = 28'h0002000;
      addr_tab[REQ_DMA] = 28'h0003000;
      wr_pat = {64{8'hA5}};
      last_rd = '0;

      rst = 1'b1;
      calib_done = 1'b1;
      req_valid = 3'b111;
      req_we = '0;
      req_wdata = '0;
      for (int i = 0; i < NREQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
      app_rdy = 1'b0;
      app_wdf_rdy = 1'b0;
      app_rd_data = '0;
      app_rd_data_valid = 1'b0;

      // Reset state, with requests and calibration present to show they are masked
      cyc();
      cyc();
      #1;
      chk("rst_ready", req_ready, 3'b000);
      chk("rst_outs", {rsp_valid, app_en, app_wdf_wren, app_wdf_end, busy, err}, 8'h00);
      chk("rst_rdata", rsp_data, '0);

      // Calibration gating
      calib_done = 1'b0;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         #1;
         chk("nocal_ready", req_ready, 3'b000);
         chk("nocal_busy", busy, 1'b0);
      end
      cyc();
      calib_done = 1'b1;

      // Round-robin reads with all three requesters held valid
      do_read(REQ_CPU, 0, {16{32'h0C0DE000}}, 3'b111);
      do_read(REQ_GPU, 0, {16{32'h1C0DE111}}, 3'b111);
      do_read(REQ_DMA, 0, {16{32'h2C0DE222}}, 3'b111);
      do_read(REQ_CPU, 0, {16{32'h3C0DE333}}, 3'b000);
      chk("rr_err", err, 1'b0);

      // GPU write with app_wdf_rdy stalled 3 cycles
      cyc();
      req_we = 3'b010;
      req_addr[REQ_GPU*ADDR_W +: ADDR_W] = 28'h0000100;
      req_wdata[REQ_GPU*DATA_W +: DATA_W] = wr_pat;
      req_valid = 3'b010;
      #1 chk("wr_grant", req_ready, 3'b010);
      cyc();
      req_valid = 3'b000;
      req_we = 3'b000;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("wr_wren_stall", {app_wdf_wren, app_wdf_end, app_en}, 3'b110);
         chk("wr_data", app_wdf_data, wr_pat);
         cyc();
      end
      app_wdf_rdy = 1'b1;
      #1 chk("wr_wren_last", {app_wdf_wren, app_wdf_end, app_en}, 3'b110);
      cyc();
      app_wdf_rdy = 1'b0;
      app_rdy = 1'b1;
      #1;
      chk("wr_cmd", {app_en, app_wdf_wren, app_cmd}, {2'b10, CMD_WRITE});
      chk("wr_addr", app_addr, 28'h0000100);
      cyc();
      app_rdy = 1'b0;
      #1;
      chk("wr_rsp", rsp_valid, 3'b010);
      chk("wr_idle", busy, 1'b0);
      chk("wr_keep_rdata", rsp_data, last_rd);

      // Lone CPU read while ptr points at DMA, command stalled 4 cycles
      cyc();
      req_valid = 3'b001;
      do_read(REQ_CPU, 4, {16{32'h4C0DE444}}, 3'b000);
      cyc();
      #1 chk("single_pulse", rsp_valid, 3'b000);

      // Stray read return in IDLE
      app_rd_data = {16{32'hDEADBEEF}};
      app_rd_data_valid = 1'b1;
      cyc();
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
      #1;
      chk("stray_err", err, 1'b1);
      chk("stray_rsp", rsp_valid, 3'b000);
      chk("stray_rdata", rsp_data, last_rd);
      for (int k = 0; k < 3; k++) cyc();
      #1 chk("err_sticky", err, 1'b1);

      // Reset while a DMA read waits for data
      cyc();
      req_valid = 3'b100;
      #1 chk("dma_grant", req_ready, 3'b100);
      cyc();
      req_valid = 3'b000;
      app_rdy = 1'b1;
      cyc();
      app_rdy = 1'b0;
      #1 chk("dma_rwait", busy, 1'b1);
      rst = 1'b1;
      #1 chk("rst_mask", {busy, err, rsp_valid}, 5'b00000);
      app_rd_data = {16{32'h5C0DE555}};
      app_rd_data_valid = 1'b1;
      cyc();
      app_rd_data_valid = 1'b0;
      app_rd_data = '0;
      rst = 1'b0;
      #1;
      chk("post_rst_rsp", rsp_valid, 3'b000);
      chk("post_rst_state", {busy, err}, 2'b00);
      req_valid = 3'b111;
      #1 chk("post_rst_ptr", req_ready, 3'b001);
      cyc();
      req_valid = 3'b000;
      #1 chk("post_rst_cmd", {app_en, app_addr}, {1'b1, addr_tab[REQ_CPU]});

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
